// File: rtl/audio_pkg.sv
// Shared types and constants for the audio record/playback sequencer.
package audio_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned CLK_DIV_DEFAULT = 50;

    typedef enum logic [2:0] {
        Idle,
        Record,
        PbRead,
        PbLoad,
        PbWait
    } state_e;

endpackage

// File: rtl/mclk_gen.sv
// Free-running microphone clock divider; tick marks the first cycle of each mclk high phase.
module mclk_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    output logic mclk_o,
    output logic tick_o
);

    localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            mclk_q, mclk_d;
    logic            tick_q, tick_d;
    logic            wrap;

    always_comb begin
        wrap   = (cnt_q == CntW'(CLK_DIV - 1));
        cnt_d  = wrap ? '0 : cnt_q + CntW'(1);
        mclk_d = wrap ? ~mclk_q : mclk_q;
        // Registered alongside mclk so tick lines up with mclk's first high cycle.
        tick_d = wrap & ~mclk_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            mclk_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mclk_q <= mclk_d;
            tick_q <= tick_d;
        end
    end

    assign mclk_o = mclk_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/audio_seq_ctrl.sv
// Record PDM bits into byte memory and play recorded bytes back to a PWM serializer.
module audio_seq_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT,
    parameter int unsigned ADDR_W  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rec_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              micData,
    output logic              mclk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic [BYTE_W-1:0] pwm_byte,
    output logic              pwm_load,
    output logic              ampSD,
    output logic              busy,
    output logic              ledrec
);

    localparam int unsigned BitW = $clog2(BYTE_W);
    localparam int unsigned LenW = ADDR_W + 1;

    logic tick;

    state_e            state_q, state_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-2:0] shift_q, shift_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BYTE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [LenW-1:0]   rec_len_q, rec_len_d;
    logic [BYTE_W-1:0] pwm_byte_q, pwm_byte_d;

    mclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_mclk_gen (
        .clk   (clk),
        .reset (reset),
        .mclk_o(mclk),
        .tick_o(tick)
    );

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rec_len_d   = rec_len_q;
        pwm_byte_d  = pwm_byte_q;

        case (state_q)
            Idle: begin
                if (rec_start) begin
                    state_d    = Record;
                    bit_cnt_d  = '0;
                    mem_addr_d = '0;
                    rec_len_d  = '0;
                end else if (play_start && rec_len_q != '0) begin
                    state_d    = PbRead;
                    mem_addr_d = '0;
                end
            end
            Record: begin
                if (tick) begin
                    shift_d   = {shift_q[BYTE_W-3:0], micData};
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(BYTE_W - 1)) begin
                        mem_we_d    = 1'b1;
                        mem_wdata_d = {shift_q, micData};
                    end
                end
                // Address advances the cycle after the write; the last address ends the take.
                if (mem_we_q) begin
                    rec_len_d = rec_len_q + LenW'(1);
                    if (mem_addr_q == '1) begin
                        state_d = Idle;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                    end
                end
            end
            PbRead: begin
                state_d = PbLoad;
            end
            PbLoad: begin
                pwm_byte_d = mem_rdata;
                bit_cnt_d  = '0;
                state_d    = PbWait;
            end
            PbWait: begin
                if (tick) begin
                    bit_cnt_d = bit_cnt_q + BitW'(1);
                    if (bit_cnt_q == BitW'(BYTE_W - 1)) begin
                        if ({1'b0, mem_addr_q} == rec_len_q - LenW'(1)) begin
                            state_d = Idle;
                        end else begin
                            mem_addr_d = mem_addr_q + ADDR_W'(1);
                            state_d    = PbRead;
                        end
                    end
                end
            end
            default: state_d = Idle;
        endcase

        // A byte not yet on the bus when stop arrives is dropped.
        if (stop) begin
            state_d  = Idle;
            mem_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= Idle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rec_len_q   <= '0;
            pwm_byte_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rec_len_q   <= rec_len_d;
            pwm_byte_q  <= pwm_byte_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pwm_load  = (state_q == PbLoad);
    assign pwm_byte  = pwm_load ? mem_rdata : pwm_byte_q;
    assign ampSD     = (state_q == PbRead) || (state_q == PbLoad) || (state_q == PbWait);
    assign ledrec    = (state_q == Record);
    assign busy      = (state_q != Idle);

endmodule

// File: tb/tb_audio_seq_ctrl.sv
// Self-checking bench for audio_seq_ctrl with a byte-memory model and a bit-level reference.
module tb_audio_seq_ctrl;

    localparam int unsigned DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rec_start = 1'b0;
    logic       play_start = 1'b0;
    logic       stop = 1'b0;
    logic       micData = 1'b0;
    logic       mclk;
    logic       mem_we;
    logic [2:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [7:0] pwm_byte;
    logic       pwm_load;
    logic       ampSD;
    logic       busy;
    logic       ledrec;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [DEPTH];
    logic [10:0] wq[$];
    logic [7:0]  stim_bytes [9];

    always #5 clk = ~clk;

    audio_seq_ctrl #(
        .CLK_DIV(2),
        .ADDR_W (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rec_start (rec_start),
        .play_start(play_start),
        .stop      (stop),
        .micData   (micData),
        .mclk      (mclk),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pwm_byte  (pwm_byte),
        .pwm_load  (pwm_load),
        .ampSD     (ampSD),
        .busy      (busy),
        .ledrec    (ledrec)
    );

    // Synchronous sample memory: read data one cycle after the address.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    end

    task automatic fill_stim(input bit fixed);
        for (int i = 0; i < 9; i++) stim_bytes[i] = fixed ? 8'hB2 : 8'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b1; rec_start = 1'b1; play_start = 1'b1; stop = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mclk !== 1'b0) begin errors++; $display("FAIL reset_mclk: got %b want 0", mclk); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 3'd0) begin errors++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
        checks++; if (mem_wdata !== 8'd0) begin errors++; $display("FAIL reset_mem_wdata: got %0h want 0", mem_wdata); end
        checks++; if (pwm_byte !== 8'd0) begin errors++; $display("FAIL reset_pwm_byte: got %0h want 0", pwm_byte); end
        checks++; if (pwm_load !== 1'b0) begin errors++; $display("FAIL reset_pwm_load: got %b want 0", pwm_load); end
        checks++; if (ampSD !== 1'b0) begin errors++; $display("FAIL reset_ampSD: got %b want 0", ampSD); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (ledrec !== 1'b0) begin errors++; $display("FAIL reset_ledrec: got %b want 0", ledrec); end
        reset = 1'b0; rec_start = 1'b0; play_start = 1'b0;
        test_play_ignored("reset_reclen_zero");
    endtask

    task automatic test_play_ignored(input string name);
        bit bad;
        bad = 1'b0;
        @(negedge clk); play_start = 1'b1;
        @(negedge clk); play_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (busy !== 1'b0 || ampSD !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL %s: play_start started playback, want ignored", name); end
    endtask

    // Feeds one stimulus bit per mclk high phase while recording; optionally stops afterwards.
    task automatic do_record(input int nbytes, input int extra, input bit both, input bit poke,
                             input bit use_stop);
        int total, given, guard, poke_cyc;
        logic prev_m;
        logic [7:0] b;
        total = nbytes * 8 + extra; given = 0; guard = 0; poke_cyc = -1;
        wq.delete();
        @(negedge clk);
        rec_start = 1'b1; play_start = both; prev_m = mclk;
        @(negedge clk);
        rec_start = 1'b0; play_start = 1'b0;
        if (both) begin
            checks++;
            if (ledrec !== 1'b1 || ampSD !== 1'b0) begin
                errors++;
                $display("FAIL rec_priority: ledrec=%b ampSD=%b want ledrec=1 ampSD=0", ledrec, ampSD);
            end
        end
        while (given < total && guard < 4000) begin
            play_start = 1'b0;
            if (poke_cyc >= 0 && guard == poke_cyc + 1) begin
                checks++;
                if (ledrec !== 1'b1 || ampSD !== 1'b0) begin
                    errors++;
                    $display("FAIL play_during_rec: ledrec=%b ampSD=%b want 1/0", ledrec, ampSD);
                end
            end
            if (mclk === 1'b1 && prev_m === 1'b0) begin
                b = stim_bytes[given / 8];
                micData = b[7 - (given % 8)];
                given++;
            end
            if (poke && poke_cyc < 0 && given == 10) begin
                play_start = 1'b1;
                poke_cyc = guard;
            end
            prev_m = mclk;
            @(negedge clk);
            guard++;
        end
        play_start = 1'b0;
        checks++;
        if (given < total) begin errors++; $display("FAIL rec_timeout: fed %0d bits want %0d", given, total); end
        if (use_stop) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
        end else begin
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || ledrec !== 1'b0) begin
            errors++;
            $display("FAIL rec_end_idle: busy=%b ledrec=%b want 0/0", busy, ledrec);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (wq.size() != nbytes) begin
            errors++;
            $display("FAIL rec_write_count: got %0d want %0d", wq.size(), nbytes);
        end
        for (int i = 0; i < wq.size() && i < nbytes; i++) begin
            checks++;
            if (wq[i] !== {3'(i), stim_bytes[i]}) begin
                errors++;
                $display("FAIL rec_write[%0d]: got addr %0d data %0h want addr %0d data %0h",
                         i, wq[i][10:8], wq[i][7:0], i, stim_bytes[i]);
            end
        end
    endtask

    // Plays back n bytes; loads 2 cycles after the request, 8 mclk periods (32 clk) apart.
    task automatic do_play(input int n);
        int   lt[$];
        logic [7:0] lb[$];
        logic amp_tr[$];
        int   last;
        bit   bad;
        @(negedge clk); play_start = 1'b1;
        @(negedge clk); play_start = 1'b0;
        for (int c = 1; c <= 32 * n + 10; c++) begin
            amp_tr.push_back(ampSD);
            if (pwm_load === 1'b1) begin
                lt.push_back(c);
                lb.push_back(pwm_byte);
            end
            @(negedge clk);
        end
        checks++;
        if (lt.size() != n) begin errors++; $display("FAIL play_count: got %0d want %0d", lt.size(), n); end
        if (lt.size() > 0) begin
            checks++;
            if (lt[0] != 2) begin errors++; $display("FAIL play_first_latency: got %0d want 2", lt[0]); end
        end
        for (int k = 0; k < lt.size() && k < n; k++) begin
            checks++;
            if (lb[k] !== stim_bytes[k]) begin
                errors++;
                $display("FAIL play_byte[%0d]: got %0h want %0h", k, lb[k], stim_bytes[k]);
            end
            if (k == 1) begin
                checks++;
                if (lt[1] - lt[0] < 33 || lt[1] - lt[0] > 36) begin
                    errors++;
                    $display("FAIL play_gap[1]: got %0d want 33..36", lt[1] - lt[0]);
                end
            end else if (k > 1) begin
                checks++;
                if (lt[k] - lt[k-1] != 32) begin
                    errors++;
                    $display("FAIL play_gap[%0d]: got %0d want 32", k, lt[k] - lt[k-1]);
                end
            end
        end
        last = (lt.size() > 0) ? lt[lt.size() - 1] : 2;
        bad = 1'b0;
        for (int c = 1; c <= last + 29 && c <= amp_tr.size(); c++) begin
            if (amp_tr[c-1] !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL play_ampSD_on: ampSD dropped during playback, want 1"); end
        checks++;
        if (ampSD !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL play_end: ampSD=%b busy=%b want 0/0", ampSD, busy);
        end
    endtask

    task automatic test_record_pattern();
        fill_stim(1'b1);
        do_record(8, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_playback();
        do_play(8);
    endtask

    task automatic test_stop();
        fill_stim(1'b0);
        do_record(3, 5, 1'b0, 1'b0, 1'b1);
        do_play(3);
    endtask

    task automatic test_priority();
        fill_stim(1'b0);
        do_record(8, 0, 1'b1, 1'b1, 1'b0);
        do_play(8);
    endtask

    task automatic test_random_stop();
        int nb, ex;
        for (int it = 0; it < 4; it++) begin
            nb = int'($urandom_range(0, 7));
            ex = int'($urandom_range(0, 7));
            fill_stim(1'b0);
            do_record(nb, ex, 1'b0, 1'b0, 1'b1);
            if (nb > 0) do_play(nb);
            else test_play_ignored("rand_empty_play");
        end
    endtask

    task automatic test_midplay_reset();
        fill_stim(1'b0);
        do_record(2, 0, 1'b0, 1'b0, 1'b1);
        @(negedge clk); play_start = 1'b1;
        @(negedge clk); play_start = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (ampSD !== 1'b1) begin errors++; $display("FAIL midplay_active: ampSD=%b want 1", ampSD); end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (ampSD !== 1'b0 || busy !== 1'b0 || pwm_byte !== 8'd0 || mem_addr !== 3'd0) begin
            errors++;
            $display("FAIL midplay_reset: ampSD=%b busy=%b pwm_byte=%0h addr=%0d want all 0",
                     ampSD, busy, pwm_byte, mem_addr);
        end
        reset = 1'b0;
        test_play_ignored("midplay_reclen_zero");
    endtask

    initial begin
        test_reset();
        test_record_pattern();
        test_playback();
        test_stop();
        test_priority();
        test_random_stop();
        test_midplay_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
